// File: rtl/mips_ctrl_ext_exmem.sv
// ID-stage main control decoder and immediate extender (combinational),
// plus the clocked EX/MEM pipeline register carrying EX results into MEM.
module mips_ctrl_ext_exmem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic [15:0] Imm16,
    output logic [1:0]  jump,
    output logic        RegDst,
    output logic [1:0]  Branch,
    output logic        MemR,
    output logic        Mem2R,
    output logic        MemW,
    output logic        RegW,
    output logic        Alusrc,
    output logic [1:0]  EXTOp,
    output logic [4:0]  Aluctrl,
    output logic [31:0] Imm32,
    input  logic        EX_MEM_WR,
    input  logic [31:0] NPC_IN,
    output logic [31:0] NPC_OUT,
    input  logic [31:0] ALU_C_IN,
    output logic [31:0] ALU_C_OUT,
    input  logic [31:0] RT_DATA_IN,
    output logic [31:0] RT_DATA_OUT,
    input  logic        ZERO_IN,
    output logic        ZERO_OUT,
    input  logic [1:0]  jump_in,
    output logic [1:0]  jump_out,
    input  logic [1:0]  Branch_IN,
    output logic [1:0]  Branch_OUT,
    input  logic [4:0]  reg_rd_in,
    output logic [4:0]  reg_rd_out,
    input  logic        MEMR_IN,
    output logic        MEMR_OUT,
    input  logic        MEMW_IN,
    output logic        MEMW_OUT,
    input  logic        REGW_IN,
    output logic        REGW_OUT,
    input  logic        MEM2R_IN,
    output logic        MEM2R_OUT
);

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_OR   = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLL  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_NOR  = 5'b01001;
    localparam logic [4:0] ALU_SLTU = 5'b01010;

    logic       r_known;
    logic [4:0] r_alu;

    // R-type funct to ALU op; r_known=0 for funct values that are not ALU ops
    always_comb begin
        r_known = 1'b1;
        r_alu   = ALU_NOP;
        case (Funct)
            6'b100000, 6'b100001: r_alu = ALU_ADD;
            6'b100010, 6'b100011: r_alu = ALU_SUB;
            6'b100100:            r_alu = ALU_AND;
            6'b100101:            r_alu = ALU_OR;
            6'b100110:            r_alu = ALU_XOR;
            6'b100111:            r_alu = ALU_NOR;
            6'b101010:            r_alu = ALU_SLT;
            6'b101011:            r_alu = ALU_SLTU;
            6'b000000:            r_alu = ALU_SLL;
            6'b000010:            r_alu = ALU_SRL;
            default:              r_known = 1'b0;
        endcase
    end

    always_comb begin
        jump    = 2'b00;
        RegDst  = 1'b0;
        Branch  = 2'b00;
        MemR    = 1'b0;
        Mem2R   = 1'b0;
        MemW    = 1'b0;
        RegW    = 1'b0;
        Alusrc  = 1'b0;
        EXTOp   = 2'b00;
        Aluctrl = ALU_NOP;
        case (OpCode)
            6'b000000: begin
                if (r_known) begin
                    RegW    = 1'b1;
                    Aluctrl = r_alu;
                end else if (Funct == 6'b001000) begin
                    jump = 2'b11;
                end
            end
            6'b001000, 6'b001001: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01; Aluctrl = ALU_ADD;
            end
            6'b001010: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b01; Aluctrl = ALU_SLT;
            end
            6'b001100: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = ALU_AND;
            end
            6'b001101: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = ALU_OR;
            end
            6'b001110: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; Aluctrl = ALU_XOR;
            end
            6'b001111: begin
                RegDst = 1'b1; Alusrc = 1'b1; RegW = 1'b1; EXTOp = 2'b10; Aluctrl = ALU_ADD;
            end
            6'b100011: begin
                MemR = 1'b1; Mem2R = 1'b1; RegW = 1'b1; RegDst = 1'b1; Alusrc = 1'b1;
                EXTOp = 2'b01; Aluctrl = ALU_ADD;
            end
            6'b101011: begin
                MemW = 1'b1; Alusrc = 1'b1; EXTOp = 2'b01; Aluctrl = ALU_ADD;
            end
            6'b000100: begin
                Branch = 2'b01; EXTOp = 2'b01; Aluctrl = ALU_SUB;
            end
            6'b000101: begin
                Branch = 2'b10; EXTOp = 2'b01; Aluctrl = ALU_SUB;
            end
            // jal only redirects; the link register write is handled elsewhere
            6'b000010: begin
                Branch = 2'b11; jump = 2'b01;
            end
            6'b000011: begin
                Branch = 2'b11; jump = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (EXTOp)
            2'b00:   Imm32 = {16'b0, Imm16};
            2'b10:   Imm32 = {Imm16, 16'b0};
            default: Imm32 = {{16{Imm16[15]}}, Imm16};
        endcase
    end

    // Reset wins over the write enable; with EX_MEM_WR low everything holds
    always_ff @(posedge clk) begin
        if (!rst) begin
            NPC_OUT     <= '0;
            ALU_C_OUT   <= '0;
            RT_DATA_OUT <= '0;
            ZERO_OUT    <= 1'b0;
            jump_out    <= 2'b00;
            Branch_OUT  <= 2'b00;
            reg_rd_out  <= 5'b0;
            MEMR_OUT    <= 1'b0;
            MEMW_OUT    <= 1'b0;
            REGW_OUT    <= 1'b0;
            MEM2R_OUT   <= 1'b0;
        end else if (EX_MEM_WR) begin
            NPC_OUT     <= NPC_IN;
            ALU_C_OUT   <= ALU_C_IN;
            RT_DATA_OUT <= RT_DATA_IN;
            ZERO_OUT    <= ZERO_IN;
            jump_out    <= jump_in;
            Branch_OUT  <= Branch_IN;
            reg_rd_out  <= reg_rd_in;
            MEMR_OUT    <= MEMR_IN;
            MEMW_OUT    <= MEMW_IN;
            REGW_OUT    <= REGW_IN;
            MEM2R_OUT   <= MEM2R_IN;
        end
    end

endmodule

// File: tb/tb_mips_ctrl_ext_exmem.sv
// Bench for mips_ctrl_ext_exmem: table-driven decode/extend reference and a
// queue-based scoreboard for the EX/MEM register.
module tb_mips_ctrl_ext_exmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [1:0]  jump;
    logic        RegDst;
    logic [1:0]  Branch;
    logic        MemR, Mem2R, MemW, RegW, Alusrc;
    logic [1:0]  EXTOp;
    logic [4:0]  Aluctrl;
    logic [31:0] Imm32;
    logic        EX_MEM_WR;
    logic [31:0] NPC_IN, NPC_OUT, ALU_C_IN, ALU_C_OUT, RT_DATA_IN, RT_DATA_OUT;
    logic        ZERO_IN, ZERO_OUT;
    logic [1:0]  jump_in, jump_out, Branch_IN, Branch_OUT;
    logic [4:0]  reg_rd_in, reg_rd_out;
    logic        MEMR_IN, MEMR_OUT, MEMW_IN, MEMW_OUT, REGW_IN, REGW_OUT, MEM2R_IN, MEM2R_OUT;

    int checks = 0;
    int failures = 0;

    mips_ctrl_ext_exmem dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Imm16(Imm16),
        .jump(jump), .RegDst(RegDst), .Branch(Branch), .MemR(MemR), .Mem2R(Mem2R),
        .MemW(MemW), .RegW(RegW), .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl),
        .Imm32(Imm32), .EX_MEM_WR(EX_MEM_WR),
        .NPC_IN(NPC_IN), .NPC_OUT(NPC_OUT), .ALU_C_IN(ALU_C_IN), .ALU_C_OUT(ALU_C_OUT),
        .RT_DATA_IN(RT_DATA_IN), .RT_DATA_OUT(RT_DATA_OUT),
        .ZERO_IN(ZERO_IN), .ZERO_OUT(ZERO_OUT), .jump_in(jump_in), .jump_out(jump_out),
        .Branch_IN(Branch_IN), .Branch_OUT(Branch_OUT),
        .reg_rd_in(reg_rd_in), .reg_rd_out(reg_rd_out),
        .MEMR_IN(MEMR_IN), .MEMR_OUT(MEMR_OUT), .MEMW_IN(MEMW_IN), .MEMW_OUT(MEMW_OUT),
        .REGW_IN(REGW_IN), .REGW_OUT(REGW_OUT), .MEM2R_IN(MEM2R_IN), .MEM2R_OUT(MEM2R_OUT)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- observation buses ----------------
    logic [16:0]  ctl_obs;
    logic [109:0] reg_obs;
    assign ctl_obs = {jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl};
    assign reg_obs = {NPC_OUT, ALU_C_OUT, RT_DATA_OUT, ZERO_OUT, jump_out, Branch_OUT,
                      reg_rd_out, MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT};

    // ---------------- reference model ----------------
    typedef struct packed { logic [1:0] ext; logic [4:0] alu; } i_ent_t;
    logic [4:0] r_alu_tbl [logic [5:0]];
    i_ent_t     i_tbl     [logic [5:0]];
    logic [109:0] model_reg;
    logic [109:0] exp_q[$];

    function automatic logic [16:0] mk(input logic [1:0] j, input logic rd, input logic [1:0] br,
                                       input logic mr, input logic m2r, input logic mw,
                                       input logic rw, input logic as, input logic [1:0] ext,
                                       input logic [4:0] alu);
        return {j, rd, br, mr, m2r, mw, rw, as, ext, alu};
    endfunction

    function automatic logic [16:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (r_alu_tbl.exists(fn)) return mk(2'd0, 0, 2'd0, 0, 0, 0, 1, 0, 2'd0, r_alu_tbl[fn]);
            if (fn == 6'b001000)      return mk(2'd3, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 5'd0);
            return '0;
        end
        if (i_tbl.exists(op)) return mk(2'd0, 1, 2'd0, 0, 0, 0, 1, 1, i_tbl[op].ext, i_tbl[op].alu);
        case (op)
            6'b100011: return mk(2'd0, 1, 2'd0, 1, 1, 0, 1, 1, 2'd1, 5'd1);
            6'b101011: return mk(2'd0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd1, 5'd1);
            6'b000100: return mk(2'd0, 0, 2'd1, 0, 0, 0, 0, 0, 2'd1, 5'd2);
            6'b000101: return mk(2'd0, 0, 2'd2, 0, 0, 0, 0, 0, 2'd1, 5'd2);
            6'b000010: return mk(2'd1, 0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 5'd0);
            6'b000011: return mk(2'd2, 0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 5'd0);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [31:0] ref_ext(input logic [1:0] ext, input logic [15:0] imm);
        int signed sv;
        if (ext == 2'b10) return {imm, 16'h0000};
        if (ext == 2'b00) return 32'(imm);
        sv = int'($signed(imm));
        return 32'(sv);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [109:0] obs, input logic [109:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic decode(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [15:0] imm);
        logic [16:0] ec;
        OpCode = op; Funct = fn; Imm16 = imm;
        #1;
        ec = ref_ctrl(op, fn);
        check({tag, "_ctl"}, 110'(ctl_obs), 110'(ec));
        check({tag, "_imm"}, 110'(Imm32), 110'(ref_ext(ec[6:5], imm)));
    endtask

    // One clock edge: apply inputs, predict, then compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic wr, input logic [109:0] din);
        rst = r; EX_MEM_WR = wr;
        {NPC_IN, ALU_C_IN, RT_DATA_IN, ZERO_IN, jump_in, Branch_IN,
         reg_rd_in, MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN} = din;
        if (!r)      model_reg = '0;
        else if (wr) model_reg = din;
        exp_q.push_back(model_reg);
        @(posedge clk);
        #1;
        check(tag, reg_obs, exp_q.pop_front());
    endtask

    function automatic logic [109:0] rand_bus();
        logic [109:0] b;
        b = {$urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    // ---------------- stimulus ----------------
    logic [5:0] known_ops [14] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] known_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h08};

    initial begin
        logic [109:0] b;
        r_alu_tbl[6'h20] = 5'd1;  r_alu_tbl[6'h21] = 5'd1;
        r_alu_tbl[6'h22] = 5'd2;  r_alu_tbl[6'h23] = 5'd2;
        r_alu_tbl[6'h24] = 5'd3;  r_alu_tbl[6'h25] = 5'd4;
        r_alu_tbl[6'h26] = 5'd8;  r_alu_tbl[6'h27] = 5'd9;
        r_alu_tbl[6'h2A] = 5'd5;  r_alu_tbl[6'h2B] = 5'd10;
        r_alu_tbl[6'h00] = 5'd6;  r_alu_tbl[6'h02] = 5'd7;
        i_tbl[6'h08] = '{2'd1, 5'd1}; i_tbl[6'h09] = '{2'd1, 5'd1};
        i_tbl[6'h0A] = '{2'd1, 5'd5}; i_tbl[6'h0C] = '{2'd0, 5'd3};
        i_tbl[6'h0D] = '{2'd0, 5'd4}; i_tbl[6'h0E] = '{2'd0, 5'd8};
        i_tbl[6'h0F] = '{2'd2, 5'd1};
        model_reg = '0;
        OpCode = '0; Funct = '0; Imm16 = '0;

        // reset with all inputs high, then first capture
        cycle("reset_clear", 1'b0, 1'b1, '1);
        cycle("reset_release", 1'b1, 1'b1, '1);
        check("npc_after_reset", 110'(NPC_OUT), 110'(32'hFFFFFFFF));
        check("rd_after_reset", 110'(reg_rd_out), 110'(5'h1F));

        // hold
        b = '0; b[77:46] = 32'h12345678;
        cycle("hold_capture", 1'b1, 1'b1, b);
        b[77:46] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 1'b0, b);
        check("hold_alu_c", 110'(ALU_C_OUT), 110'(32'h12345678));

        // reset beats write enable, then capture only when WR returns
        cycle("reset_prio", 1'b0, 1'b1, rand_bus());
        cycle("post_reset_nowr", 1'b1, 1'b0, rand_bus());
        cycle("post_reset_wr", 1'b1, 1'b1, rand_bus());

        // extender directed values
        decode("ext_ori", 6'b001101, 6'h00, 16'h8001);
        check("ext00_const", 110'(Imm32), 110'(32'h00008001));
        decode("ext_addi", 6'b001000, 6'h00, 16'h8001);
        check("ext01_const", 110'(Imm32), 110'(32'hFFFF8001));
        decode("ext_lui", 6'b001111, 6'h00, 16'h8001);
        check("ext10_const", 110'(Imm32), 110'(32'h80010000));

        // directed decode
        for (int i = 0; i < 13; i++) decode("rtype", 6'h00, known_fn[i], 16'h1234);
        decode("rtype_unknown", 6'h00, 6'b111111, 16'h0000);
        for (int i = 1; i < 14; i++) decode("optype", known_ops[i], 6'h2A, 16'h7FFF);
        decode("lw", 6'b100011, 6'h00, 16'hFFFC);
        check("lw_const", 110'(ctl_obs), 110'(17'b00_1_00_1_1_0_1_1_01_00001));
        decode("bad_op", 6'b111111, 6'h20, 16'hABCD);
        check("bad_op_zero", 110'(ctl_obs), 110'(17'd0));

        // randomized decode
        for (int i = 0; i < 200; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known_ops[$urandom_range(0, 13)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known_fn[$urandom_range(0, 12)];
            decode("rand_dec", op, fn, 16'($urandom));
        end

        // randomized register traffic
        for (int i = 0; i < 200; i++)
            cycle("rand_reg", ($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0), rand_bus());

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
